// File: rtl/micro_waves_pkg.sv
// Shared definitions for the microwave timer chain: FSM encoding, key decode, clock default.
package micro_waves_pkg;

  localparam int CLK_HZ_DEFAULT = 1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_LOAD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  // Callers guarantee a one-hot input; index of the set bit is the BCD digit.
  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] oh);
    logic [3:0] bcd;
    bcd = 4'd0;
    for (int i = 0; i < 10; i++)
      if (oh[i]) bcd = 4'(i);
    return bcd;
  endfunction

endpackage

// File: rtl/prescaler_1hz.sv
// Free-running divider: one-cycle pulse every CLK_HZ clocks.
module prescaler_1hz
  import micro_waves_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic clearn,
  output logic pgt_1hz
);

  localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pgt_q;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // Pulse is registered alongside the count so it is high exactly while cnt_q==LAST.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      cnt_q <= '0;
      pgt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pgt_q <= (cnt_d == LAST);
    end
  end

  assign pgt_1hz = pgt_q;

endmodule

// File: rtl/keypad_timer_entry.sv
// Keypad capture, debounce and digit load strobes for the min/sec timer, plus 1 Hz enable.
// Optional KEYPAD_MULTIKEY_ERR_EN adds a sticky key_err output for multi-key presses.
module keypad_timer_entry
  import micro_waves_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       entry_en,
  output logic [3:0] d,
  output logic       loadn,
  output logic       pgt_1hz,
`ifdef KEYPAD_MULTIKEY_ERR_EN
  output logic       key_err,
`endif
  output logic [1:0] digit_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    DIG_MAX  = 2'(MAX_DIGITS);

  state_e        state_q, state_d;
  logic [9:0]    key_q, key_d;
  logic [DW-1:0] dbc_q, dbc_d;
  logic [3:0]    d_q, d_d;
  logic [1:0]    dig_q, dig_d;
  logic          one_hot;

  assign one_hot = $onehot(keypad);

`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic multi;
  logic err_q, err_d;
  assign multi   = (keypad != 10'd0) && !one_hot;
  assign err_d   = err_q | (multi && (state_q == ST_IDLE || state_q == ST_DEBOUNCE));
  assign key_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dbc_d   = dbc_q;
    d_d     = d_q;
    dig_d   = dig_q;
    case (state_q)
      ST_IDLE:
        if (one_hot && entry_en && dig_q < DIG_MAX) begin
          key_d   = keypad;
          dbc_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      ST_DEBOUNCE: begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
        if (multi) state_d = ST_WAIT_REL;
        else
`endif
        if (keypad != key_q) state_d = ST_IDLE;
        else if (!entry_en)  state_d = ST_WAIT_REL;
        else begin
          dbc_d = dbc_q + 1'b1;
          // d and the count update on the LOAD entry edge so d is stable while loadn is low.
          if (dbc_q == DBC_LAST) begin
            state_d = ST_LOAD;
            d_d     = onehot_to_bcd(key_q);
            dig_d   = dig_q + 1'b1;
          end
        end
      end
      ST_LOAD:     state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (keypad == 10'd0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      dbc_q   <= '0;
      d_q     <= '0;
      dig_q   <= '0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dbc_q   <= dbc_d;
      d_q     <= d_d;
      dig_q   <= dig_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign loadn       = (state_q != ST_LOAD);
  assign d           = d_q;
  assign digit_count = dig_q;

  prescaler_1hz #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk     (clk),
    .clearn  (clearn),
    .pgt_1hz (pgt_1hz)
  );

endmodule

// File: tb/tb_keypad_timer_entry.sv
// Directed test-plan scenarios then random keypad traffic, checked each cycle against a behavioural model.
module tb_keypad_timer_entry;

  localparam int HZ   = 10;
  localparam int DC   = 4;
  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       entry_en = 1'b1;
  logic [9:0] keypad = '0;
  logic [3:0] d;
  logic       loadn, pgt_1hz;
  logic [1:0] digit_count;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic       key_err;
`endif

  always #5 clk = ~clk;

  keypad_timer_entry #(.CLK_HZ(HZ), .DEBOUNCE_CYCLES(DC), .MAX_DIGITS(MAXD)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .keypad      (keypad),
    .entry_en    (entry_en),
    .d           (d),
    .loadn       (loadn),
    .pgt_1hz     (pgt_1hz),
`ifdef KEYPAD_MULTIKEY_ERR_EN
    .key_err     (key_err),
`endif
    .digit_count (digit_count)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a press is a run of identical one-hot samples; the DC-th repeat after
  // acceptance emits a strobe, after which the key must be released.
  int         m_stable = 0;     // matching samples so far while a press is tracked
  bit         m_track  = 0;     // a press is being counted
  bit         m_relwait = 0;    // must see an all-zero keypad before a new press
  bit         m_strobe = 0;     // strobe cycle
  logic [9:0] m_key = '0;
  int         m_d = 0, m_cnt = 0, m_pre = 0;
  bit         m_err = 0;

  function automatic int key_idx(input logic [9:0] k);
    int r = 0;
    for (int i = 0; i < 10; i++) if (k[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    int ones;
    ones = $countones(keypad);
    if (!clearn) begin
      m_stable = 0; m_track = 0; m_relwait = 0; m_strobe = 0;
      m_d = 0; m_cnt = 0; m_pre = 0; m_err = 0;
    end else begin
      m_pre = (m_pre + 1) % HZ;
      if (ones >= 2 && !m_strobe && !m_relwait) m_err = 1;
      if (m_strobe) begin
        m_strobe = 0; m_relwait = 1;
      end else if (m_relwait) begin
        if (keypad == 0) m_relwait = 0;
      end else if (!m_track) begin
        if (ones == 1 && entry_en && m_cnt < MAXD) begin
          m_track = 1; m_key = keypad; m_stable = 0;
        end
      end else begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
        if (ones >= 2) begin m_track = 0; m_relwait = 1; end
        else
`endif
        if (keypad != m_key) m_track = 0;
        else if (!entry_en) begin m_track = 0; m_relwait = 1; end
        else begin
          m_stable++;
          if (m_stable == DC) begin
            m_track = 0; m_strobe = 1;
            m_d = key_idx(m_key); m_cnt++;
          end
        end
      end
    end
  end

  task automatic check_outputs();
    chk("loadn", int'(loadn), m_strobe ? 0 : 1);
    chk("d", int'(d), m_d);
    chk("digit_count", int'(digit_count), m_cnt);
    chk("pgt_1hz", int'(pgt_1hz), (m_pre == HZ - 1) ? 1 : 0);
`ifdef KEYPAD_MULTIKEY_ERR_EN
    chk("key_err", int'(key_err), int'(m_err));
`endif
  endtask

  task automatic drive(input logic [9:0] kp, input logic en, input logic cl, input int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      keypad = kp; entry_en = en; clearn = cl;
    end
  endtask

  function automatic logic [9:0] key(input int i);
    logic [9:0] k = '0;
    k[i] = 1'b1;
    return k;
  endfunction

  int strobes = 0;
  always @(negedge clk) if (clearn && !loadn) strobes++;

  initial begin
    int kind, len;
    logic [9:0] kp;
    drive('0, 1, 0, 2);
    drive('0, 1, 1, 25);
    chk("no_strobe_idle", strobes, 0);
    drive(key(5), 1, 1, 10); drive('0, 1, 1, 3);
    chk("one_strobe_key5", strobes, 1);
    drive(key(7), 1, 1, 2); drive('0, 1, 1, 2);
    drive(key(7), 1, 1, 6); drive('0, 1, 1, 2);
    chk("bounce_then_key7", strobes, 2);
    drive('0, 1, 0, 1);
    foreach (kp[i]) ; // no-op keeps kp declared for random phase
    drive(key(1), 1, 1, 7); drive('0, 1, 1, 2);
    drive(key(3), 1, 1, 7); drive('0, 1, 1, 2);
    drive(key(0), 1, 1, 7); drive('0, 1, 1, 2);
    drive(key(9), 1, 1, 7); drive('0, 1, 1, 2);
    chk("saturate_count", int'(digit_count), MAXD);
    drive('0, 1, 0, 1);
    drive(key(4), 0, 1, 6); drive(key(4), 1, 1, 8); drive('0, 1, 1, 2);
    drive(key(8), 1, 1, 2); drive(key(8), 0, 1, 3); drive(key(8), 1, 1, 8);
    drive('0, 1, 1, 2);
    drive(key(2) | key(6), 1, 1, 8); drive('0, 1, 1, 2);
    drive('0, 1, 0, 1);
    drive(key(1), 1, 1, 5); drive(key(1), 1, 0, 1); drive('0, 1, 1, 2);
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 10);
      if (kind == 0)       drive('0, 1, 0, $urandom_range(1, 2));
      else if (kind < 4)   drive('0, 1, 1, $urandom_range(1, 4));
      else if (kind < 6) begin
        kp = 10'($urandom_range(0, 1023));
        drive(kp, 1, 1, len);
      end else
        drive(key($urandom_range(0, 9)), ($urandom_range(0, 4) != 0), 1, len);
    end
    drive('0, 1, 1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
